// File: rtl/ks_sub_pipe_32b.sv
// ks_sub_pipe_32b: 3-stage pipelined Kogge-Stone subtractor, a - b - bin.
// Valid/ready flow control with combinational stall back-propagation.
module ks_sub_pipe_32b #(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RST_DATA = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_valid,
   output logic             i_ready,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_bin,
   output logic             o_valid,
   input  logic             i_out_ready,
   output logic [WIDTH-1:0] o_diff,
   output logic             o_borrow,
   output logic             o_ovf
);

   logic adv1, adv2, adv3;
   logic ld1, ld2, ld3;

   logic             v1_q, v1_d;
   logic [WIDTH-1:0] p1_q, p1_d;
   logic [WIDTH-1:0] g1_q, g1_d;
   logic             cin1_q, cin1_d;
   logic             a1_q, a1_d;
   logic             b1_q, b1_d;

   logic             v2_q, v2_d;
   logic [WIDTH-1:0] p2_q, p2_d;
   logic [WIDTH-1:0] g2_q, g2_d;
   logic [WIDTH-1:8] gp2_q, gp2_d;
   logic             cin2_q, cin2_d;
   logic             a2_q, a2_d;
   logic             b2_q, b2_d;

   logic             v3_q, v3_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_q, borrow_d;
   logic             ovf_q, ovf_d;

   logic [WIDTH-1:0] nb;
   logic [WIDTH-1:0] g0f;
   logic [WIDTH-1:0] gl1, gl2, gl3;
   logic [WIDTH-1:2] pl1;
   logic [WIDTH-1:4] pl2;
   logic [WIDTH-1:8] pl3;
   logic [WIDTH-1:0] gl4, gl5;
   logic [WIDTH-1:16] pl4;
   logic [WIDTH-1:0] sum;

   // A stage may move when it is empty or the stage after it moves.
   assign adv3 = ~v3_q | i_out_ready;
   assign adv2 = ~v2_q | adv3;
   assign adv1 = ~v1_q | adv2;
   assign ld1  = adv1 & i_valid;
   assign ld2  = adv2 & v1_q;
   assign ld3  = adv3 & v2_q;

   assign i_ready  = adv1;
   assign o_valid  = v3_q;
   assign o_diff   = diff_q;
   assign o_borrow = borrow_q;
   assign o_ovf    = ovf_q;

   assign nb = ~i_b;

   always_comb begin
      v1_d   = adv1 ? i_valid : v1_q;
      p1_d   = p1_q;
      g1_d   = g1_q;
      cin1_d = cin1_q;
      a1_d   = a1_q;
      b1_d   = b1_q;
      if (ld1) begin
         p1_d   = i_a ^ nb;
         g1_d   = i_a & nb;
         cin1_d = ~i_bin;
         a1_d   = i_a[WIDTH-1];
         b1_d   = i_b[WIDTH-1];
      end
   end

   // Levels 1-3; group P is kept only where a later level consumes it.
   always_comb begin
      g0f    = g1_q;
      g0f[0] = g1_q[0] | (p1_q[0] & cin1_q);
      gl1 = g0f;
      for (int i = 1; i < WIDTH; i++)
         gl1[i] = g0f[i] | (p1_q[i] & g0f[i-1]);
      for (int i = 2; i < WIDTH; i++)
         pl1[i] = p1_q[i] & p1_q[i-1];
      gl2 = gl1;
      for (int i = 2; i < WIDTH; i++)
         gl2[i] = gl1[i] | (pl1[i] & gl1[i-2]);
      for (int i = 4; i < WIDTH; i++)
         pl2[i] = pl1[i] & pl1[i-2];
      gl3 = gl2;
      for (int i = 4; i < WIDTH; i++)
         gl3[i] = gl2[i] | (pl2[i] & gl2[i-4]);
      for (int i = 8; i < WIDTH; i++)
         pl3[i] = pl2[i] & pl2[i-4];
   end

   always_comb begin
      v2_d   = adv2 ? v1_q : v2_q;
      p2_d   = p2_q;
      g2_d   = g2_q;
      gp2_d  = gp2_q;
      cin2_d = cin2_q;
      a2_d   = a2_q;
      b2_d   = b2_q;
      if (ld2) begin
         p2_d   = p1_q;
         g2_d   = gl3;
         gp2_d  = pl3;
         cin2_d = cin1_q;
         a2_d   = a1_q;
         b2_d   = b1_q;
      end
   end

   // Levels 4-5 finish the carries; sum uses carry into each bit.
   always_comb begin
      gl4 = g2_q;
      for (int i = 8; i < WIDTH; i++)
         gl4[i] = g2_q[i] | (gp2_q[i] & g2_q[i-8]);
      for (int i = 16; i < WIDTH; i++)
         pl4[i] = gp2_q[i] & gp2_q[i-8];
      gl5 = gl4;
      for (int i = 16; i < WIDTH; i++)
         gl5[i] = gl4[i] | (pl4[i] & gl4[i-16]);
      sum = p2_q ^ {gl5[WIDTH-2:0], cin2_q};
   end

   always_comb begin
      v3_d     = adv3 ? v2_q : v3_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
      ovf_d    = ovf_q;
      if (ld3) begin
         diff_d   = sum;
         borrow_d = ~gl5[WIDTH-1];
         ovf_d    = (a2_q ^ b2_q) & (a2_q ^ sum[WIDTH-1]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q   <= 1'b0;
         p1_q   <= RST_DATA;
         g1_q   <= RST_DATA;
         cin1_q <= 1'b0;
         a1_q   <= 1'b0;
         b1_q   <= 1'b0;
      end else begin
         v1_q   <= v1_d;
         p1_q   <= p1_d;
         g1_q   <= g1_d;
         cin1_q <= cin1_d;
         a1_q   <= a1_d;
         b1_q   <= b1_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2_q   <= 1'b0;
         p2_q   <= RST_DATA;
         g2_q   <= RST_DATA;
         gp2_q  <= RST_DATA[WIDTH-1:8];
         cin2_q <= 1'b0;
         a2_q   <= 1'b0;
         b2_q   <= 1'b0;
      end else begin
         v2_q   <= v2_d;
         p2_q   <= p2_d;
         g2_q   <= g2_d;
         gp2_q  <= gp2_d;
         cin2_q <= cin2_d;
         a2_q   <= a2_d;
         b2_q   <= b2_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v3_q     <= 1'b0;
         diff_q   <= RST_DATA;
         borrow_q <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         v3_q     <= v3_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
         ovf_q    <= ovf_d;
      end
   end

endmodule

// File: tb/tb_ks_sub_pipe_32b.sv
// tb_ks_sub_pipe_32b: directed vector table, reset/stall sequences
// and a randomised stream against an arithmetic reference.
module tb_ks_sub_pipe_32b;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        bin;
      logic [31:0] diff;
      logic        borrow;
      logic        ovf;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_valid;
   logic        i_ready;
   logic [31:0] i_a;
   logic [31:0] i_b;
   logic        i_bin;
   logic        o_valid;
   logic        i_out_ready;
   logic [31:0] o_diff;
   logic        o_borrow;
   logic        o_ovf;

   int n_pass = 0;
   int n_total = 0;
   vec_t tbl[13];

   ks_sub_pipe_32b dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_valid     (i_valid),
      .i_ready     (i_ready),
      .i_a         (i_a),
      .i_b         (i_b),
      .i_bin       (i_bin),
      .o_valid     (o_valid),
      .i_out_ready (i_out_ready),
      .o_diff      (o_diff),
      .o_borrow    (o_borrow),
      .o_ovf       (o_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      else
         n_pass++;
   endtask

   function automatic logic [33:0] ref_sub(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic bin);
      logic [32:0] r;
      logic        ov;
      r  = {1'b0, a} - {1'b0, b} - {32'b0, bin};
      ov = (a[31] ^ b[31]) & (a[31] ^ r[31]);
      return {ov, r[32], r[31:0]};
   endfunction

   // One isolated operand: exact 3-edge latency, then the result.
   task automatic apply_vec(input vec_t v, input int idx);
      @(negedge clk);
      i_valid = 1'b1;
      i_a = v.a;
      i_b = v.b;
      i_bin = v.bin;
      #1;
      chk($sformatf("v%0d_iready", idx), 64'(i_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      i_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_early", idx), 64'(o_valid), 64'd0);
      @(negedge clk);
      chk($sformatf("v%0d_valid", idx), 64'(o_valid), 64'd1);
      chk($sformatf("v%0d_diff", idx), 64'(o_diff), 64'(v.diff));
      chk($sformatf("v%0d_borrow", idx), 64'(o_borrow), 64'(v.borrow));
      chk($sformatf("v%0d_ovf", idx), 64'(o_ovf), 64'(v.ovf));
   endtask

   task automatic run_stream(input int n, input bit rnd);
      logic [33:0] expq[$];
      logic [33:0] held;
      logic [33:0] e;
      logic        held_v;
      int          sent;
      int          got;
      int          cyc;
      sent = 0;
      got = 0;
      cyc = 0;
      held_v = 1'b0;
      held = '0;
      while (got < n && cyc < 60000) begin
         @(negedge clk);
         i_valid = (sent < n) && (rnd ? ($urandom_range(3) != 0) : 1'b1);
         i_a = $urandom;
         i_b = $urandom;
         i_bin = 1'($urandom_range(1));
         if (rnd)
            i_out_ready = ($urandom_range(3) != 0);
         else
            i_out_ready = !(cyc >= 4 && cyc <= 9);
         #1;
         if (!rnd && cyc == 5)
            chk("stall_iready", 64'(i_ready), 64'd0);
         if (held_v)
            chk("hold", 64'({o_valid, o_ovf, o_borrow, o_diff}),
                64'({1'b1, held}));
         if (o_valid && i_out_ready) begin
            if (expq.size() == 0) begin
               chk("spurious", 64'd1, 64'd0);
            end else begin
               e = expq.pop_front();
               chk(rnd ? "rand_res" : "stall_res",
                   64'({o_ovf, o_borrow, o_diff}), 64'(e));
            end
            got++;
         end
         if (i_valid && i_ready) begin
            expq.push_back(ref_sub(i_a, i_b, i_bin));
            sent++;
         end
         held_v = o_valid && !i_out_ready;
         held = {o_ovf, o_borrow, o_diff};
         cyc++;
      end
      chk(rnd ? "rand_count" : "stall_count", 64'(got), 64'(n));
      chk(rnd ? "rand_left" : "stall_left", 64'(expq.size()), 64'd0);
      @(negedge clk);
      i_valid = 1'b0;
      i_out_ready = 1'b1;
   endtask

   initial begin
      logic any_v;
      tbl[0]  = '{32'h0000000A, 32'h00000003, 1'b0, 32'h00000007, 1'b0, 1'b0};
      tbl[1]  = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0};
      tbl[2]  = '{32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};
      tbl[3]  = '{32'h00000000, 32'h00000001, 1'b1, 32'hFFFFFFFE, 1'b1, 1'b0};
      tbl[4]  = '{32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1};
      tbl[5]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
      tbl[6]  = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b1};
      tbl[7]  = '{32'h12345678, 32'h02345678, 1'b0, 32'h10000000, 1'b0, 1'b0};
      tbl[8]  = '{32'h00000005, 32'h00000005, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
      tbl[9]  = '{32'h00010000, 32'h00000001, 1'b0, 32'h0000FFFF, 1'b0, 1'b0};
      tbl[10] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b0, 1'b0};
      tbl[11] = '{32'h7FFFFFFF, 32'h80000000, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b1};
      tbl[12] = '{32'h80000000, 32'h7FFFFFFF, 1'b0, 32'h00000001, 1'b0, 1'b1};

      rst_n = 1'b0;
      i_valid = 1'b0;
      i_a = '0;
      i_b = '0;
      i_bin = 1'b0;
      i_out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_valid", 64'(o_valid), 64'd0);
      chk("rst_diff", 64'(o_diff), 64'd0);
      chk("rst_borrow", 64'(o_borrow), 64'd0);
      chk("rst_ovf", 64'(o_ovf), 64'd0);
      chk("rst_iready", 64'(i_ready), 64'd1);
      rst_n = 1'b1;

      for (int i = 0; i < 13; i++)
         apply_vec(tbl[i], i);

      // Reset with a full, stalled pipeline.
      @(negedge clk);
      i_out_ready = 1'b0;
      for (int k = 5; k < 8; k++) begin
         i_valid = 1'b1;
         i_a = tbl[k].a;
         i_b = tbl[k].b;
         i_bin = tbl[k].bin;
         @(negedge clk);
      end
      i_valid = 1'b0;
      chk("pre_rst_valid", 64'(o_valid), 64'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_state", 64'({o_valid, o_borrow, o_ovf, i_ready, o_diff}),
          64'({1'b0, 1'b0, 1'b0, 1'b1, 32'h0}));
      @(posedge clk);
      @(negedge clk);
      chk("mid_rst_edge", 64'({o_valid, i_ready, o_diff}),
          64'({1'b0, 1'b1, 32'h0}));
      rst_n = 1'b1;
      i_out_ready = 1'b1;
      any_v = 1'b0;
      repeat (5) begin
         @(negedge clk);
         any_v = any_v | o_valid;
      end
      chk("no_survivor", 64'(any_v), 64'd0);
      apply_vec(tbl[0], 100);

      run_stream(8, 1'b0);
      run_stream(10000, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
